chain_latency_meter: RTL and testbench
======================================

Name: chain_latency_meter

Overview:
- Measurement stage wrapped around one delay-chain instance: drives the chain's data input and consumes the chain's data output.
- On each start request it launches a single edge into the chain, then counts clock cycles until that edge arrives at the chain output.
- Reports the latency and keeps running min/max/sample-count statistics, so the total chain depth can be characterised on silicon.

Parameters:
- CNT_W, 16, width of the latency counter and of the latency/min/max results.
- TIMEOUT, 1023, maximum cycles to wait for arrival before abandoning a measurement. Must satisfy 1 <= TIMEOUT <= 2^CNT_W-1.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  single-cycle request to launch one measurement; ignored unless idle
- clear  input  1  synchronous clear of statistics (min/max/count/timeout_seen)
- chain_din  output  1  launch level driven into the delay chain input
- chain_dout  input  1  delay chain output, synchronous to clk
- busy  output  1  measurement in progress
- done  output  1  one-cycle pulse: arrival detected, latency valid
- timeout  output  1  one-cycle pulse: TIMEOUT reached without arrival
- latency  output  CNT_W  last measured latency, held until the next done
- lat_min  output  CNT_W  smallest latency since reset/clear
- lat_max  output  CNT_W  largest latency since reset/clear
- n_meas  output  8  number of successful measurements, saturating at 255
- timeout_seen  output  1  sticky flag, set by any timeout

Behaviour:
- Reset values:
  - chain_din=0, busy=0, done=0, timeout=0, latency=0
  - lat_min=all-ones, lat_max=0, n_meas=0, timeout_seen=0
  - FSM=IDLE, cnt=0, expected=0
- FSM states: IDLE, WAIT.
- IDLE:
  - If start=1: chain_din <= ~chain_din, expected <= ~chain_din, cnt <= 0, busy <= 1, go to WAIT.
  - Otherwise hold.
- WAIT, evaluated every edge:
  - cnt_next = cnt+1.
  - If chain_dout==expected: latency <= cnt_next, done pulse, stats update, busy <= 0, go to IDLE.
  - Else if cnt_next==TIMEOUT: timeout pulse, timeout_seen <= 1, latency unchanged, busy <= 0, go to IDLE.
  - Else cnt <= cnt_next.
  - If arrival and TIMEOUT coincide on the same edge, arrival wins: done is pulsed, timeout is not.
- Latency definition:
  - Latency counts rising edges from the edge that toggles chain_din (edge k) up to and including the first edge that samples chain_dout==expected.
  - Minimum value is 1 (combinational passthrough). One register stage gives 2. P registers give P+1.
- Stats update on done:
  - lat_min <= min(lat_min, latency_new); lat_max <= max(lat_max, latency_new).
  - n_meas <= n_meas+1, saturating at 255.
- start while busy: ignored, no queuing.
- clear:
  - Resets lat_min, lat_max, n_meas and timeout_seen to their reset values. Does not affect the FSM, chain_din or latency.
  - If clear and done fall on the same edge, clear wins and the new sample is discarded from the stats; latency still updates.
- chain_din holds its level between measurements. Launches therefore alternate 0->1 and 1->0, exercising both edge polarities.
- rst mid-measurement: everything returns to its reset values immediately. The chain may still carry an old edge, so the next start is only meaningful after the chain has settled (caller's responsibility).
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: CHAIN_LAT_SYNC_EN.
- Defined:
  - chain_dout passes through a 2-flop synchroniser before comparison, so the chain may run on an unrelated clock or be asynchronous.
  - All reported latencies increase by exactly 2. Minimum latency becomes 3.
- Undefined: chain_dout is compared directly, with latency exactly as defined above.

Test Plan:
- Passthrough (chain_dout tied to chain_din), one start -> chain_din 0->1; done one cycle later; latency=1; lat_min=lat_max=1; n_meas=1.
- Model 5-stage register chain, 3 starts -> chain_din toggles 1,0,1; each latency=6; n_meas=3; busy high for exactly 6 cycles per run.
- chain_dout stuck 0 after a 1 launch, TIMEOUT=20 -> timeout pulse on the 20th edge after launch; timeout_seen=1; latency, lat_min, lat_max and n_meas unchanged.
- Chains of 2 then 9 registers, then clear -> lat_min=3 and lat_max=10 before clear; all-ones/0/0 after clear. Clear coinciding with done -> latency updates, stats stay cleared.
- start pulsed during WAIT, and start held high across two measurements -> mid-WAIT start ignored; held start relaunches on the first IDLE cycle after done.
- rst asserted 3 cycles into WAIT -> busy=0 and chain_din=0 immediately, no done/timeout pulse; with CHAIN_LAT_SYNC_EN, passthrough gives latency=3.

Source files
------------

// File: rtl/chain_latency_meter.sv
// chain_latency_meter: launches one edge into an external delay chain on each
// start request and counts clock edges until that edge appears at the chain
// output. Keeps running min/max/count statistics and a sticky timeout flag.
// Optional build macro: CHAIN_LAT_SYNC_EN puts a 2-flop synchroniser on
// chain_dout; every reported latency then grows by 2.
module chain_latency_meter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    output logic             chain_din,
    input  logic             chain_dout,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] latency,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max,
    output logic [7:0]       n_meas,
    output logic             timeout_seen
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             expected, expected_nx;
    logic             din_nx, busy_nx, done_nx, timeout_nx, tseen_nx;
    logic [CNT_W-1:0] latency_nx, min_nx, max_nx;
    logic [7:0]       n_nx;
    logic             dout_s;

`ifdef CHAIN_LAT_SYNC_EN
    logic sync1, sync2;

    // Two-flop synchroniser so the chain may be asynchronous to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= chain_dout;
            sync2 <= sync1;
        end
    end

    assign dout_s = sync2;
`else
    assign dout_s = chain_dout;
`endif

    assign cnt_inc = cnt + 1'b1;

    // State and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            expected     <= 1'b0;
            chain_din    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            latency      <= '0;
            lat_min      <= '1;
            lat_max      <= '0;
            n_meas       <= '0;
            timeout_seen <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            expected     <= expected_nx;
            chain_din    <= din_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            timeout      <= timeout_nx;
            latency      <= latency_nx;
            lat_min      <= min_nx;
            lat_max      <= max_nx;
            n_meas       <= n_nx;
            timeout_seen <= tseen_nx;
        end
    end

    // Next-state, measurement and statistics logic; arrival beats timeout,
    // clear beats a same-cycle statistics update
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        expected_nx = expected;
        din_nx      = chain_din;
        busy_nx     = busy;
        done_nx     = 1'b0;
        timeout_nx  = 1'b0;
        latency_nx  = latency;
        min_nx      = lat_min;
        max_nx      = lat_max;
        n_nx        = n_meas;
        tseen_nx    = timeout_seen;

        case (state)
            IDLE: begin
                if (start) begin
                    din_nx      = ~chain_din;
                    expected_nx = ~chain_din;
                    cnt_nx      = '0;
                    busy_nx     = 1'b1;
                    state_nx    = WAIT;
                end
            end
            WAIT: begin
                if (dout_s == expected) begin
                    latency_nx = cnt_inc;
                    done_nx    = 1'b1;
                    busy_nx    = 1'b0;
                    state_nx   = IDLE;
                    if (cnt_inc < lat_min) min_nx = cnt_inc;
                    if (cnt_inc > lat_max) max_nx = cnt_inc;
                    if (n_meas != 8'hFF)   n_nx   = n_meas + 8'd1;
                end else if (cnt_inc == TIMEOUT_C) begin
                    timeout_nx = 1'b1;
                    tseen_nx   = 1'b1;
                    busy_nx    = 1'b0;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (clear) begin
            min_nx   = '1;
            max_nx   = '0;
            n_nx     = '0;
            tseen_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_chain_latency_meter.sv
// Testbench for chain_latency_meter: behavioural register-chain model with
// selectable depth (or a stuck output), table of measurements, then directed
// sequences for timeout, clear, start handling and mid-measurement reset.
module tb_chain_latency_meter;

`ifdef CHAIN_LAT_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        chain_din, chain_dout;
    logic        busy, done, timeout, timeout_seen;
    logic [15:0] latency, lat_min, lat_max;
    logic [7:0]  n_meas;

    int          depth = 0;
    logic        stuck = 1'b0;
    logic        stuck_val = 1'b0;
    logic [15:0] sr = '0;

    int n_pass = 0;
    int n_total = 0;

    chain_latency_meter #(.CNT_W(16), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .chain_din(chain_din), .chain_dout(chain_dout),
        .busy(busy), .done(done), .timeout(timeout),
        .latency(latency), .lat_min(lat_min), .lat_max(lat_max),
        .n_meas(n_meas), .timeout_seen(timeout_seen)
    );

    always #5 clk = ~clk;

    // Delay chain model: depth registers, depth 0 is a combinational wire
    always @(posedge clk) sr <= {sr[14:0], chain_din};
    assign chain_dout = stuck ? stuck_val : ((depth == 0) ? chain_din : sr[depth-1]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic settle(input int d);
        depth = d;
        repeat (16) tick();
    endtask

    // Wait for done or timeout with a cycle budget; cycles counted from launch edge
    task automatic wait_end(inout int cycles, inout int busy_cnt, output bit got_to);
        got_to = 1'b0;
        while (!done && !timeout && cycles < 200) begin
            tick();
            cycles++;
            if (busy) busy_cnt++;
        end
        got_to = timeout;
        chk("wait_bound", (cycles < 200) ? 1 : 0, 1);
    endtask

    task automatic launch_and_wait(output int cycles, output int busy_cnt, output bit got_to);
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        busy_cnt = busy ? 1 : 0;
        wait_end(cycles, busy_cnt, got_to);
    endtask

    typedef struct {
        bit   clr_before;
        int   depth;
        int   exp_lat;
        int   exp_min;
        int   exp_max;
        int   exp_n;
        logic exp_din;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc, bc;
        bit to;
        logic din_save;
        logic [15:0] lat_save;

        vecs[0] = '{0, 0, 1,  1, 1,  1, 1'b1};
        vecs[1] = '{1, 5, 6,  6, 6,  1, 1'b0};
        vecs[2] = '{0, 5, 6,  6, 6,  2, 1'b1};
        vecs[3] = '{0, 5, 6,  6, 6,  3, 1'b0};
        vecs[4] = '{1, 2, 3,  3, 3,  1, 1'b1};
        vecs[5] = '{0, 9, 10, 3, 10, 2, 1'b0};

        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_din", chain_din, 0);
        chk("rst_lat", latency, 0);
        chk("rst_min", lat_min, 16'hFFFF);
        chk("rst_max", lat_max, 0);
        chk("rst_n", n_meas, 0);
        chk("rst_tseen", timeout_seen, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].clr_before) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
            end
            settle(vecs[i].depth);
            launch_and_wait(cyc, bc, to);
            chk("tbl_timeout", to, 0);
            chk("tbl_cycles", cyc, vecs[i].exp_lat + S);
            chk("tbl_busy_cycles", bc, vecs[i].exp_lat + S);
            chk("tbl_done", done, 1);
            chk("tbl_latency", latency, vecs[i].exp_lat + S);
            chk("tbl_min", lat_min, vecs[i].exp_min + S);
            chk("tbl_max", lat_max, vecs[i].exp_max + S);
            chk("tbl_n", n_meas, vecs[i].exp_n);
            chk("tbl_din", chain_din, vecs[i].exp_din);
            tick();
            chk("tbl_done_pulse", done, 0);
        end

        // Timeout: output stuck at the pre-launch level
        stuck_val = chain_din;
        stuck = 1'b1;
        settle(0);
        lat_save = latency;
        launch_and_wait(cyc, bc, to);
        chk("to_pulse", to, 1);
        chk("to_cycles", cyc, 20);
        chk("to_done", done, 0);
        chk("to_tseen", timeout_seen, 1);
        chk("to_busy", busy, 0);
        chk("to_latency", latency, lat_save);
        chk("to_min", lat_min, 3 + S);
        chk("to_max", lat_max, 10 + S);
        chk("to_n", n_meas, 2);
        tick();
        chk("to_pulse_end", timeout, 0);
        chk("to_tseen_sticky", timeout_seen, 1);
        stuck = 1'b0;

        // Standalone clear
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_min", lat_min, 16'hFFFF);
        chk("clr_max", lat_max, 0);
        chk("clr_n", n_meas, 0);
        chk("clr_tseen", timeout_seen, 0);
        chk("clr_latency", latency, lat_save);

        // Clear on the same edge as done
        settle(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4 + S - 1) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("cd_done", done, 1);
        chk("cd_latency", latency, 4 + S);
        chk("cd_min", lat_min, 16'hFFFF);
        chk("cd_max", lat_max, 0);
        chk("cd_n", n_meas, 0);

        // Start pulsed mid-WAIT is ignored
        settle(6);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 3;
        bc = 0;
        wait_end(cyc, bc, to);
        chk("mid_cycles", cyc, 7 + S);
        chk("mid_latency", latency, 7 + S);
        chk("mid_n", n_meas, 1);
        din_save = chain_din;
        repeat (5) tick();
        chk("mid_no_relaunch_busy", busy, 0);
        chk("mid_no_relaunch_din", chain_din, din_save);

        // Start held high across two measurements
        settle(1);
        din_save = chain_din;
        start = 1'b1;
        tick();
        cyc = 0;
        bc = 0;
        wait_end(cyc, bc, to);
        chk("held_lat1", latency, 2 + S);
        tick();
        chk("held_relaunch_busy", busy, 1);
        chk("held_relaunch_din", chain_din, din_save);
        start = 1'b0;
        cyc = 0;
        bc = 0;
        wait_end(cyc, bc, to);
        chk("held_cycles2", cyc, 2 + S);
        chk("held_n", n_meas, 3);

        // Reset three cycles into WAIT
        settle(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_din", chain_din, 0);
        chk("mr_done", done, 0);
        chk("mr_timeout", timeout, 0);
        chk("mr_n", n_meas, 0);
        repeat (2) tick();
        rst = 1'b0;
        settle(0);
        chk("mr_no_pulse", {done, timeout}, 0);
        launch_and_wait(cyc, bc, to);
        chk("pt_cycles", cyc, 1 + S);
        chk("pt_latency", latency, 1 + S);
        chk("pt_n", n_meas, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
